// File: rtl/hs_unpack_if.sv
// hs_unpack_if: valid/ready stream bundle around the width-down converter.
//   data_in_vld/data_in/data_in_nslice/data_in_rdy : wide word side
//   data_out_vld/data_out/data_out_last/data_out_rdy : narrow slice side
//   master = stream source/sink around the converter, slave = converter.
interface hs_unpack_if #(
    parameter int DATA_IN_WIDTH  = 256,
    parameter int DATA_OUT_WIDTH = 64,
    parameter int log2_RATIO     = 2
);
    logic                      data_in_vld;
    logic [DATA_IN_WIDTH-1:0]  data_in;
    logic [log2_RATIO-1:0]     data_in_nslice;
    logic                      data_in_rdy;
    logic                      data_out_vld;
    logic [DATA_OUT_WIDTH-1:0] data_out;
    logic                      data_out_last;
    logic                      data_out_rdy;

    modport master (
        output data_in_vld, data_in, data_in_nslice, data_out_rdy,
        input  data_in_rdy, data_out_vld, data_out, data_out_last
    );

    modport slave (
        input  data_in_vld, data_in, data_in_nslice, data_out_rdy,
        output data_in_rdy, data_out_vld, data_out, data_out_last
    );
endinterface

// File: rtl/hs_unpack.sv
// hs_unpack: splits one wide word into DATA_OUT_WIDTH slices, LSB first, one per cycle.
//   clk, rst (async, active-high)
//   bus.slave: data_in_vld/data_in/data_in_nslice -> data_in_rdy,
//              data_out_vld/data_out/data_out_last <- data_out_rdy
module hs_unpack #(
    parameter int DATA_IN_WIDTH  = 256,
    parameter int DATA_OUT_WIDTH = 64,
    parameter int RATIO          = 4,
    parameter int log2_RATIO     = 2
) (
    input logic       clk,
    input logic       rst,
    hs_unpack_if.slave bus
);
    if (DATA_IN_WIDTH != RATIO * DATA_OUT_WIDTH) begin : g_bad_width
        $error("hs_unpack: DATA_IN_WIDTH must equal RATIO*DATA_OUT_WIDTH");
    end

    logic                     buf_vld;
    logic [DATA_IN_WIDTH-1:0] buf_data;
    logic [log2_RATIO-1:0]    buf_last_idx;
    logic [log2_RATIO-1:0]    idx;
    logic                     last;
    logic                     wr_en;
    logic                     rd_en;

    assign last             = buf_vld & (idx == buf_last_idx);
    assign bus.data_out_vld  = buf_vld;
    assign bus.data_out      = buf_data[idx*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
    assign bus.data_out_last = last;
    // Refill in the same cycle the last slice leaves, so words stream without a bubble.
    assign bus.data_in_rdy   = ~rst & (~buf_vld | (bus.data_out_rdy & last));
    assign wr_en             = bus.data_in_vld & bus.data_in_rdy;
    assign rd_en             = buf_vld & bus.data_out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld      <= 1'b0;
            buf_data     <= '0;
            buf_last_idx <= '0;
            idx          <= '0;
        end else if (wr_en) begin
            buf_vld      <= 1'b1;
            buf_data     <= bus.data_in;
            buf_last_idx <= bus.data_in_nslice;
            idx          <= '0;
        end else if (rd_en) begin
            buf_vld <= ~last;
            idx     <= last ? '0 : idx + log2_RATIO'(1);
        end
    end
endmodule

// File: tb/tb_hs_unpack.sv
// tb_hs_unpack: randomized self-checking bench for hs_unpack against a slice-queue model.
module tb_hs_unpack;
    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } slice_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    slice_t q[$];

    logic        obs_vld, obs_last, obs_rdy;
    logic [63:0] obs_data;
    logic        e_vld, e_last, e_rdy;
    logic [63:0] e_data;

    hs_unpack_if bus ();

    hs_unpack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Model: queue holds every slice still owed downstream; the converter holds at most one word.
    task automatic cycle(input logic v, input logic [255:0] d, input logic [1:0] ns, input logic r);
        slice_t s;
        @(negedge clk);
        bus.data_in_vld    = v;
        bus.data_in        = d;
        bus.data_in_nslice = ns;
        bus.data_out_rdy   = r;
        #1;
        obs_vld  = bus.data_out_vld;
        obs_data = bus.data_out;
        obs_last = bus.data_out_last;
        obs_rdy  = bus.data_in_rdy;
        e_vld  = q.size() != 0;
        e_data = e_vld ? q[0].d : 64'd0;
        e_last = e_vld ? q[0].l : 1'b0;
        e_rdy  = !rst && (q.size() == 0 || (q.size() == 1 && r));
        if (e_vld && r) void'(q.pop_front());
        if (v && e_rdy) begin
            for (int i = 0; i <= int'(ns); i++) begin
                s.d = d[i*64 +: 64];
                s.l = (i == int'(ns));
                q.push_back(s);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.data_out_vld !== 1'b0 || bus.data_out_last !== 1'b0 || bus.data_out !== 64'd0 || bus.data_in_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: vld=%b last=%b data=%h rdy=%b, required 0 0 0 0",
                     bus.data_out_vld, bus.data_out_last, bus.data_out, bus.data_in_rdy);
        end
        rst = 1'b0;
        q.delete();
        cycle(1'b0, 256'd0, 2'd0, 1'b1);
        n_cmp++;
        if (obs_vld !== 1'b0 || obs_last !== 1'b0 || obs_data !== 64'd0 || obs_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: vld=%b last=%b data=%h rdy=%b, required 0 0 0 1",
                     obs_vld, obs_last, obs_data, obs_rdy);
        end
    endtask

    task automatic test_full_word();
        logic [255:0] w;
        w = {64'd4, 64'd3, 64'd2, 64'd1};
        cycle(1'b1, w, 2'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 256'd0, 2'd0, 1'b1);
            n_cmp++;
            if (obs_vld !== 1'b1 || obs_data !== 64'(k + 1) || obs_last !== (k == 3) || obs_rdy !== (k == 3)) begin
                n_err++;
                $display("FAIL full_word[%0d]: vld=%b data=%h last=%b rdy=%b, required 1 %h %b %b",
                         k, obs_vld, obs_data, obs_last, obs_rdy, 64'(k + 1), k == 3, k == 3);
            end
        end
        cycle(1'b0, 256'd0, 2'd0, 1'b1);
        n_cmp++;
        if (obs_vld !== 1'b0 || obs_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL full_word_idle: vld=%b rdy=%b, required 0 1", obs_vld, obs_rdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] w[3];
        int wi = 0;
        int nv = 0;
        int np = 0;
        for (int i = 0; i < 3; i++) w[i] = rnd256();
        for (int c = 0; c < 14; c++) begin
            cycle(wi < 3, wi < 3 ? w[wi] : 256'd0, 2'd3, 1'b1);
            if (wi < 3 && e_rdy) wi++;
            n_cmp++;
            if (obs_vld !== e_vld || obs_rdy !== e_rdy || (e_vld && (obs_data !== e_data || obs_last !== e_last))) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: vld=%b data=%h last=%b rdy=%b, required %b %h %b %b",
                         c, obs_vld, obs_data, obs_last, obs_rdy, e_vld, e_data, e_last, e_rdy);
            end
            if (c >= 1 && c <= 12) begin
                nv += int'(obs_vld);
                np += int'(obs_vld & obs_rdy);
            end
        end
        n_cmp++;
        if (nv != 12 || np != 3) begin
            n_err++;
            $display("FAIL back_to_back_gapless: valid=%0d rdy_pulses=%0d, required 12 3", nv, np);
        end
    endtask

    task automatic test_partial();
        logic [255:0] w0, w1;
        int ns_out = 0;
        w0 = rnd256();
        w1 = rnd256();
        cycle(1'b1, w0, 2'd0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cycle(c == 0, w1, 2'd2, 1'b1);
            n_cmp++;
            if (obs_vld !== e_vld || obs_rdy !== e_rdy || (e_vld && (obs_data !== e_data || obs_last !== e_last))) begin
                n_err++;
                $display("FAIL partial[%0d]: vld=%b data=%h last=%b rdy=%b, required %b %h %b %b",
                         c, obs_vld, obs_data, obs_last, obs_rdy, e_vld, e_data, e_last, e_rdy);
            end
            ns_out += int'(obs_vld);
        end
        n_cmp++;
        if (ns_out != 4) begin
            n_err++;
            $display("FAIL partial_count: slices=%0d, required 4", ns_out);
        end
    endtask

    task automatic test_backpressure();
        logic        pat[12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1};
        logic [63:0] pd = '0;
        logic        pl = 1'b0;
        logic        stalled = 1'b0;
        cycle(1'b1, rnd256(), 2'd3, 1'b1);
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, rnd256(), 2'd1, pat[c]);
            n_cmp++;
            if (obs_vld !== e_vld || obs_rdy !== e_rdy || (e_vld && (obs_data !== e_data || obs_last !== e_last))) begin
                n_err++;
                $display("FAIL backpressure[%0d]: vld=%b data=%h last=%b rdy=%b, required %b %h %b %b",
                         c, obs_vld, obs_data, obs_last, obs_rdy, e_vld, e_data, e_last, e_rdy);
            end
            if (stalled) begin
                n_cmp++;
                if (obs_data !== pd || obs_last !== pl) begin
                    n_err++;
                    $display("FAIL backpressure_stable[%0d]: data=%h last=%b, required %h %b", c, obs_data, obs_last, pd, pl);
                end
            end
            stalled = obs_vld & ~pat[c];
            pd = obs_data;
            pl = obs_last;
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] w2;
        w2 = rnd256();
        cycle(1'b1, rnd256(), 2'd3, 1'b1);
        cycle(1'b0, 256'd0, 2'd0, 1'b1);
        cycle(1'b0, 256'd0, 2'd0, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.data_out_vld !== 1'b0 || bus.data_out_last !== 1'b0 || bus.data_in_rdy !== 1'b0 || bus.data_out !== 64'd0) begin
            n_err++;
            $display("FAIL reset_mid_async: vld=%b last=%b rdy=%b data=%h, required 0 0 0 0",
                     bus.data_out_vld, bus.data_out_last, bus.data_in_rdy, bus.data_out);
        end
        q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle(c == 1, w2, 2'd3, 1'b1);
            n_cmp++;
            if (obs_vld !== e_vld || obs_rdy !== e_rdy || (e_vld && (obs_data !== e_data || obs_last !== e_last))) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: vld=%b data=%h last=%b rdy=%b, required %b %h %b %b",
                         c, obs_vld, obs_data, obs_last, obs_rdy, e_vld, e_data, e_last, e_rdy);
            end
            if (c == 2) begin
                n_cmp++;
                if (obs_vld !== 1'b1 || obs_data !== w2[63:0]) begin
                    n_err++;
                    $display("FAIL reset_mid_slice0: vld=%b data=%h, required 1 %h", obs_vld, obs_data, w2[63:0]);
                end
            end
        end
        for (int c = 0; c < 3; c++) cycle(1'b0, 256'd0, 2'd0, 1'b1);
    endtask

    task automatic test_random();
        logic         v = 1'b0;
        logic [255:0] w = '0;
        logic [1:0]   ns = '0;
        logic         r;
        int           got = 0;
        int           want = 0;
        for (int c = 0; c < 400; c++) begin
            if (!v) begin
                v  = ($urandom_range(0, 2) != 0);
                w  = rnd256();
                ns = 2'($urandom_range(0, 3));
            end
            r = (c >= 380) || ($urandom_range(0, 3) != 0);
            if (c >= 380) v = 1'b0;
            cycle(v, w, ns, r);
            if (v && e_rdy) begin
                want += int'(ns) + 1;
                v = 1'b0;
            end
            got += int'(obs_vld & r);
            n_cmp++;
            if (obs_vld !== e_vld || obs_rdy !== e_rdy || (e_vld && (obs_data !== e_data || obs_last !== e_last))) begin
                n_err++;
                $display("FAIL random[%0d]: vld=%b data=%h last=%b rdy=%b, required %b %h %b %b",
                         c, obs_vld, obs_data, obs_last, obs_rdy, e_vld, e_data, e_last, e_rdy);
            end
        end
        n_cmp++;
        if (got != want || q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: delivered=%0d pending=%0d, required %0d 0", got, q.size(), want);
        end
    endtask

    initial begin
        bus.data_in_vld    = 1'b0;
        bus.data_in        = '0;
        bus.data_in_nslice = '0;
        bus.data_out_rdy   = 1'b0;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
